// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the arbiter and the memory.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport master (
    input  i_read, i_addr,
    input  d_read, d_write, d_addr, d_writedata,
    input  mem_readdata, mem_busywait,
    output i_readdata, i_busywait,
    output d_readdata, d_busywait,
    output mem_read, mem_write, mem_addr, mem_writedata
  );

  modport slave (
    output i_read, i_addr,
    output d_read, d_write, d_addr, d_writedata,
    output mem_readdata, mem_busywait,
    input  i_readdata, i_busywait,
    input  d_readdata, d_busywait,
    input  mem_read, mem_write, mem_addr, mem_writedata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and data (D) requesters.
// FAIR_ARB_EN: round-robin on simultaneous requests; default is D-over-I priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic CLK,
  input logic RESET,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    D_ACCESS,
    I_ACCESS
  } state_t;

  state_t state;
  logic   d_done;
  logic   i_done;
  logic   last_grant;
  logic   d_req;
  logic   i_req;
  logic   d_elig;
  logic   i_elig;
  logic   grant_d;
  logic   grant_i;

  assign d_req  = bus.d_read | bus.d_write;
  assign i_req  = bus.i_read;
  assign d_elig = d_req & ~d_done;
  assign i_elig = i_req & ~i_done;

  // last_grant: 1 = D was served last, 0 = I
`ifdef FAIR_ARB_EN
  assign grant_d = d_elig & (~i_elig | ~last_grant);
`else
  assign grant_d = d_elig;
`endif
  assign grant_i = i_elig & ~grant_d;

  assign bus.d_busywait = d_req & ~d_done;
  assign bus.i_busywait = i_req & ~i_done;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state             <= IDLE;
      d_done            <= 1'b0;
      i_done            <= 1'b0;
      last_grant        <= 1'b0;
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.mem_addr      <= {ADDR_W{1'b0}};
      bus.mem_writedata <= {DATA_W{1'b0}};
      bus.i_readdata    <= {DATA_W{1'b0}};
      bus.d_readdata    <= {DATA_W{1'b0}};
    end else begin
      d_done <= 1'b0;
      i_done <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant_d: begin
              state             <= D_ACCESS;
              bus.mem_addr      <= bus.d_addr;
              bus.mem_writedata <= bus.d_writedata;
              bus.mem_write     <= bus.d_write;
              bus.mem_read      <= ~bus.d_write;
            end
            grant_i: begin
              state        <= I_ACCESS;
              bus.mem_addr <= bus.i_addr;
              bus.mem_read <= 1'b1;
            end
            default: ;
          endcase
        end
        D_ACCESS: begin
          if (!bus.mem_busywait) begin
            state         <= IDLE;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            d_done        <= d_req;
            last_grant    <= 1'b1;
            if (bus.mem_read)
              bus.d_readdata <= bus.mem_readdata;
          end
        end
        I_ACCESS: begin
          if (!bus.mem_busywait) begin
            state          <= IDLE;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            i_done         <= i_req;
            last_grant     <= 1'b0;
            bus.i_readdata <= bus.mem_readdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
